// File: rtl/conversor_bin_bcd_if.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd_if
// Bundles the signals between the calculator datapath and the binary-to-BCD
// converter.
//   master : calculator / display side (drives START, IN, COUT_IN;
//            reads BCD, NDIG, OVF, BUSY, DONE)
//   slave  : the converter itself
// Signals:
//   START   level request; a conversion launches on its 0->1 transition
//   IN      unsigned binary value to convert
//   COUT_IN calculator carry, captured together with IN
//   BCD     packed BCD result, digit 0 (units) in BCD[3:0]
//   NDIG    number of significant digits, 1..N_DIG
//   OVF     registered copy of COUT_IN for the displayed result
//   BUSY    high while a conversion is in progress
//   DONE    one-cycle pulse when BCD/NDIG/OVF were just updated
// -----------------------------------------------------------------------------
interface conversor_bin_bcd_if #(
  parameter int N_BITS = 40,
  parameter int N_DIG  = 13
);
  logic                 START;
  logic [N_BITS-1:0]    IN;
  logic                 COUT_IN;
  logic [4*N_DIG-1:0]   BCD;
  logic [3:0]           NDIG;
  logic                 OVF;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, IN, COUT_IN,
    input  BCD, NDIG, OVF, BUSY, DONE
  );

  modport slave (
    input  START, IN, COUT_IN,
    output BCD, NDIG, OVF, BUSY, DONE
  );
endinterface

// File: rtl/conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one
// input bit per clock. A conversion launches on a 0->1 edge of START while
// idle, runs N_BITS shift iterations, then publishes BCD, NDIG and OVF in a
// single FIN cycle together with a one-cycle DONE pulse.
// Ports:
//   CLK  single clock, rising edge
//   RST  synchronous, active-high reset
//   bus  conversor_bin_bcd_if.slave (START, IN, COUT_IN in;
//        BCD, NDIG, OVF, BUSY, DONE out)
// -----------------------------------------------------------------------------
module conversor_bin_bcd #(
  parameter int N_BITS = 40,
  parameter int N_DIG  = 13
) (
  input  logic                 CLK,
  input  logic                 RST,
  conversor_bin_bcd_if.slave   bus
);

  localparam int CNT_W = $clog2(N_BITS);
  localparam int ACC_W = 4 * N_DIG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   start_q;
  logic [N_BITS-1:0]      shreg_q;
  logic [ACC_W-1:0]       acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_cap_q;
  logic [ACC_W-1:0]       bcd_q;
  logic [3:0]             ndig_q;
  logic                   ovf_q;
  logic                   busy_q;
  logic                   done_q;

  logic [ACC_W-1:0]        acc_adj;
  logic [ACC_W+N_BITS-1:0] shift_d;
  logic [3:0]              ndig_d;
  logic                    launch;

  // Launch only on a fresh rising edge of START while idle.
  assign launch = bus.START & ~start_q & (state_q == IDLE);

  // Add-3 correction on every digit that would exceed 9 after doubling.
  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_adj
    assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                (acc_q[4*gi +: 4] + 4'd3) : acc_q[4*gi +: 4];
  end

  // Shift the corrected accumulator and the binary register as one word so
  // the MSB of the binary value enters the units digit.
  assign shift_d = {acc_adj, shreg_q} << 1;

  // Highest nonzero digit decides the significant-digit count (minimum 1).
  always_comb begin
    ndig_d = 4'd1;
    for (int i = 0; i < N_DIG; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) ndig_d = 4'(i + 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;   // a START still high when RST drops must not launch
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      bcd_q     <= '0;
      ndig_q    <= 4'd1;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= bus.START;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            shreg_q   <= bus.IN;
            ovf_cap_q <= bus.COUT_IN;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= shift_d[ACC_W+N_BITS-1 -: ACC_W];
          shreg_q <= shift_d[N_BITS-1:0];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_BITS - 1)) state_q <= FIN;
        end
        FIN: begin
          bcd_q   <= acc_q;
          ovf_q   <= ovf_cap_q;
          ndig_q  <= ndig_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BCD  = bcd_q;
  assign bus.NDIG = ndig_q;
  assign bus.OVF  = ovf_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
module tb_conversor_bin_bcd;

  localparam int N_BITS = 40;
  localparam int N_DIG  = 13;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  conversor_bin_bcd_if #(.N_BITS(N_BITS), .N_DIG(N_DIG)) bus ();

  conversor_bin_bcd #(.N_BITS(N_BITS), .N_DIG(N_DIG)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic logic [4*N_DIG-1:0] ref_bcd(input longint unsigned v);
    logic [4*N_DIG-1:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < N_DIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_ndig(input longint unsigned v);
    int n;
    longint unsigned t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return 4'(n);
  endfunction

  // Sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Launch one conversion and wait (bounded) for DONE. IN/COUT_IN are
  // scrambled after launch; the result must not depend on them.
  task automatic run_conv(input logic [N_BITS-1:0] val, input logic cout,
                          output logic [4*N_DIG-1:0] bcd, output logic [3:0] ndig,
                          output logic ovf, output int latency, output int busy_cnt);
    bus.START = 1'b0;
    tick();
    bus.IN      = val;
    bus.COUT_IN = cout;
    bus.START   = 1'b1;
    tick();                       // edge t0
    latency  = -1;
    busy_cnt = bus.BUSY ? 1 : 0;
    for (int k = 1; k <= 80; k++) begin
      bus.IN      = {$urandom, $urandom};
      bus.COUT_IN = $urandom_range(0, 1);
      tick();
      if (bus.DONE) begin
        latency = k;
        break;
      end
      if (bus.BUSY) busy_cnt++;
    end
    bcd  = bus.BCD;
    ndig = bus.NDIG;
    ovf  = bus.OVF;
  endtask

  task automatic check_result(input string name, input logic [N_BITS-1:0] val,
                              input logic cout);
    logic [4*N_DIG-1:0] bcd;
    logic [3:0] ndig;
    logic ovf;
    int lat, bc;
    run_conv(val, cout, bcd, ndig, ovf, lat, bc);
    checks++;
    if (lat !== 41) begin
      errors++;
      $display("FAIL %s latency got %0d expected 41", name, lat);
    end
    checks++;
    if (bcd !== ref_bcd(64'(val))) begin
      errors++;
      $display("FAIL %s bcd got %h expected %h", name, bcd, ref_bcd(64'(val)));
    end
    checks++;
    if (ndig !== ref_ndig(64'(val))) begin
      errors++;
      $display("FAIL %s ndig got %0d expected %0d", name, ndig, ref_ndig(64'(val)));
    end
    checks++;
    if (ovf !== cout) begin
      errors++;
      $display("FAIL %s ovf got %0b expected %0b", name, ovf, cout);
    end
    $display("%s: IN=%0d COUT=%0b -> BCD=%h NDIG=%0d OVF=%0b lat=%0d",
             name, val, cout, bcd, ndig, ovf, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.START = 1'b0; bus.IN = '0; bus.COUT_IN = 1'b0;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    checks++;
    if (bus.BCD !== '0 || bus.NDIG !== 4'd1 || bus.OVF !== 1'b0 ||
        bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs got BCD=%h NDIG=%0d OVF=%b BUSY=%b DONE=%b expected 0/1/0/0/0",
               bus.BCD, bus.NDIG, bus.OVF, bus.BUSY, bus.DONE);
    end
    $display("reset: BCD=%h NDIG=%0d", bus.BCD, bus.NDIG);
  endtask

  task automatic test_zero();
    check_result("zero", 40'd0, 1'b0);
  endtask

  task automatic test_known();
    logic [4*N_DIG-1:0] bcd;
    logic [3:0] ndig;
    logic ovf;
    int lat, bc;
    run_conv(40'd1234567890, 1'b0, bcd, ndig, ovf, lat, bc);
    checks++;
    if (bcd !== 52'h0001234567890 || ndig !== 4'd10) begin
      errors++;
      $display("FAIL known bcd/ndig got %h/%0d expected 0001234567890/10", bcd, ndig);
    end
    checks++;
    if (bc !== 41) begin
      errors++;
      $display("FAIL known busy_cycles got %0d expected 41", bc);
    end
    $display("known: BCD=%h NDIG=%0d busy=%0d", bcd, ndig, bc);
  endtask

  task automatic test_max();
    logic [4*N_DIG-1:0] bcd;
    logic [3:0] ndig;
    logic ovf;
    int lat, bc;
    run_conv(40'hFF_FFFF_FFFF, 1'b1, bcd, ndig, ovf, lat, bc);
    checks++;
    if (bcd !== 52'h1099511627775 || ndig !== 4'd13 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL max got %h/%0d/%b expected 1099511627775/13/1", bcd, ndig, ovf);
    end
    $display("max: BCD=%h NDIG=%0d OVF=%b", bcd, ndig, ovf);
  endtask

  task automatic test_held();
    int dones;
    bus.START = 1'b0;
    tick();
    bus.IN = 40'd99; bus.COUT_IN = 1'b0; bus.START = 1'b1;
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.DONE) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL held done_pulses got %0d expected 1", dones);
    end
    checks++;
    if (bus.BCD !== 52'h99 || bus.NDIG !== 4'd2) begin
      errors++;
      $display("FAIL held bcd/ndig got %h/%0d expected 99/2", bus.BCD, bus.NDIG);
    end
    $display("held: dones=%0d BCD=%h NDIG=%0d", dones, bus.BCD, bus.NDIG);
  endtask

  task automatic test_ignore();
    int dones;
    bus.START = 1'b0;
    tick();
    bus.IN = 40'd500; bus.COUT_IN = 1'b0; bus.START = 1'b1;
    tick();                       // launch
    for (int k = 0; k < 9; k++) tick();
    bus.START = 1'b0;
    tick();
    bus.START = 1'b1; bus.IN = 40'd7;   // rise mid-conversion
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.DONE) dones++;
    end
    checks++;
    if (dones !== 1 || bus.BCD !== 52'h500) begin
      errors++;
      $display("FAIL ignore got dones=%0d BCD=%h expected 1/500", dones, bus.BCD);
    end
    $display("ignore: dones=%0d BCD=%h", dones, bus.BCD);
    check_result("after_ignore", 40'd7, 1'b0);
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.START = 1'b0;
    tick();
    bus.IN = 40'd42; bus.COUT_IN = 1'b1; bus.START = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (bus.BCD !== '0 || bus.NDIG !== 4'd1 || bus.BUSY !== 1'b0 || bus.OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs got BCD=%h NDIG=%0d BUSY=%b OVF=%b expected 0/1/0/0",
               bus.BCD, bus.NDIG, bus.BUSY, bus.OVF);
    end
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.DONE || bus.BUSY) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid no_launch got %0d active cycles expected 0", dones);
    end
    $display("reset_mid: active_cycles=%0d", dones);
    check_result("after_reset", 40'd42, 1'b0);
  endtask

  task automatic test_random();
    logic [N_BITS-1:0] v;
    for (int n = 0; n < 20; n++) begin
      v = {$urandom, $urandom};
      if (n % 4 == 1) v = v >> $urandom_range(1, 39);  // shorter values too
      check_result("random", v, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_max();
    test_held();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
